// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
// Holds the FSM state encoding, default divisors and the divisor validity check.
package clk_sched_pkg;

    localparam int unsigned SCHED_NUM_CH = 3;
    localparam int unsigned SCHED_DIV_W  = 8;
    localparam int unsigned CFG_MAX_W    = 256;

    localparam logic [SCHED_NUM_CH*SCHED_DIV_W-1:0] SCHED_DEF_DIV = {8'd4, 8'd2, 8'd1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } sched_state_t;

    // True when every one of num_ch packed divisors (div_w bits each) is nonzero.
    function automatic logic div_valid(input logic [CFG_MAX_W-1:0] divs,
                                       input int unsigned num_ch,
                                       input int unsigned div_w);
        logic                 ok;
        logic [CFG_MAX_W-1:0] mask;
        ok   = 1'b1;
        mask = '1;
        mask = ~(mask << div_w);
        for (int unsigned i = 0; i < num_ch; i++) begin
            ok = ok & (|((divs >> (i * div_w)) & mask));
        end
        return ok;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided channel: wrap counter, clock-enable strobe and 50% toggle output.
// The divisor register lives here and is reloaded at common wrap points or in IDLE.
module clk_div_channel
    import clk_sched_pkg::*;
#(
    parameter int unsigned      DIV_W = SCHED_DIV_W,
    parameter logic [DIV_W-1:0] DEF   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             ce,
    output logic             div_clk
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;

    assign ce = run && (cnt == div - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= DEF;
            cnt     <= '0;
            div_clk <= 1'b0;
        end else begin
            if (load) begin
                div <= load_div;
            end
            if (clear) begin
                cnt     <= '0;
                div_clk <= 1'b0;
            end else if (run) begin
                cnt <= (ce || load) ? '0 : cnt + DIV_W'(1);
                if (ce) begin
                    div_clk <= ~div_clk;
                end
            end
        end
    end

endmodule

// File: rtl/clk_enable_scheduler.sv
// Phase-locked clock-enable generator with run-time divisor reprogramming.
// New divisors take effect only on a common wrap (sync) or while idle.
module clk_enable_scheduler
    import clk_sched_pkg::*;
#(
    parameter int unsigned                NUM_CH  = SCHED_NUM_CH,
    parameter int unsigned                DIV_W   = SCHED_DIV_W,
    parameter logic [NUM_CH*DIV_W-1:0]    DEF_DIV = SCHED_DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cfg_req,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    output logic                    cfg_ack,
    output logic                    cfg_err,
    output logic                    busy,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       div_clk,
    output logic                    sync
);

    localparam int unsigned CFG_W = NUM_CH * DIV_W;

    sched_state_t         state, state_nxt;
    logic [CFG_W-1:0]     shadow, shadow_nxt, load_div;
    logic [CFG_MAX_W-1:0] cfg_ext;
    logic                 ack_seen, ack_seen_nxt;
    logic                 ack_nxt, err_nxt, busy_nxt;
    logic                 cfg_ok, req_ok, load, clear, run;

    always_comb begin
        cfg_ext            = '0;
        cfg_ext[CFG_W-1:0] = cfg_div;
    end

    assign cfg_ok = div_valid(cfg_ext, NUM_CH, DIV_W);
    // ack_seen blocks a request still held high after its own ack.
    assign req_ok = cfg_req && !ack_seen && !busy;
    assign run    = (state != IDLE);
    assign clear  = (state == IDLE) || !en;
    assign sync   = &ce;

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        busy_nxt   = busy;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        load       = 1'b0;
        load_div   = shadow;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    ack_nxt  = 1'b1;
                    err_nxt  = !cfg_ok;
                    load     = cfg_ok;
                    load_div = cfg_div;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (req_ok) begin
                    if (cfg_ok) begin
                        state_nxt  = PEND;
                        shadow_nxt = cfg_div;
                        busy_nxt   = 1'b1;
                    end else begin
                        ack_nxt = 1'b1;
                        err_nxt = 1'b1;
                    end
                end
            end
            PEND: begin
                // Dropping en still applies the shadow, so the ack is never lost.
                if (!en || sync) begin
                    state_nxt = en ? RUN : IDLE;
                    load      = 1'b1;
                    ack_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ack_seen_nxt = ack_nxt | (ack_seen & cfg_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= '0;
            ack_seen <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            ack_seen <= ack_seen_nxt;
            cfg_ack  <= ack_nxt;
            cfg_err  <= err_nxt;
            busy     <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .DIV_W (DIV_W),
            .DEF   (DEF_DIV[i*DIV_W +: DIV_W])
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .clear    (clear),
            .load     (load),
            .load_div (load_div[i*DIV_W +: DIV_W]),
            .ce       (ce[i]),
            .div_clk  (div_clk[i])
        );
    end

endmodule
